junction_controller: RTL and testbench

JUNCTION_CONTROLLER -- requirements
Module: junction_controller

---
 rtl/junction_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_junction_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/junction_controller.sv
// ---------------------------------------------------------------------------
// junction_controller
//
// Purpose
//   Traffic-light controller for a two-road junction with a pedestrian
//   crossing. Road A rests on green. A road-B vehicle or a pedestrian
//   request ends road-A green once the minimum green time has elapsed.
//   Each request is held in a pending flag until it is served.
//   Pedestrians are served before road B. After a walk phase the
//   controller always returns to road A, so a waiting road-B vehicle gets
//   a fresh minimum road-A green before it is served.
//
// Ports
//   clk      in   single clock, rising edge active
//   rst      in   asynchronous, active-high reset
//   car_b    in   road-B vehicle sensor (level or pulse)
//   ped_req  in   pedestrian button (level or pulse)
//   a_red, a_amber, a_green  out  road-A lamps
//   b_red, b_amber, b_green  out  road-B lamps
//   walk     out  pedestrian walk lamp
//
// The lamps are Moore outputs. They are held in a register that is loaded
// with the lamp pattern of the next state, so they always show the lamp
// pattern of the current state register. There is no combinational path
// from car_b or ped_req to any lamp.
// ---------------------------------------------------------------------------
module junction_controller #(
    parameter int T_MIN_GREEN = 8,
    parameter int T_AMBER     = 3,
    parameter int T_RED_AMBER = 2,
    parameter int T_ALL_RED   = 1,
    parameter int T_B_GREEN   = 6,
    parameter int T_WALK      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic car_b,
    input  logic ped_req,
    output logic a_red,
    output logic a_amber,
    output logic a_green,
    output logic b_red,
    output logic b_amber,
    output logic b_green,
    output logic walk
);

    typedef enum logic [3:0] {
        ST_AG   = 4'd0,
        ST_AA   = 4'd1,
        ST_AR1  = 4'd2,
        ST_BRA  = 4'd3,
        ST_BG   = 4'd4,
        ST_BA   = 4'd5,
        ST_AR2  = 4'd6,
        ST_ARA  = 4'd7,
        ST_WALK = 4'd8
    } state_t;

    // Last counter value of each timed state. A timed state leaves on the
    // cycle where the counter equals its duration minus one.
    localparam logic [7:0] MIN_GREEN_LAST = 8'(T_MIN_GREEN - 1);
    localparam logic [7:0] AMBER_LAST     = 8'(T_AMBER - 1);
    localparam logic [7:0] RED_AMBER_LAST = 8'(T_RED_AMBER - 1);
    localparam logic [7:0] ALL_RED_LAST   = 8'(T_ALL_RED - 1);
    localparam logic [7:0] B_GREEN_LAST   = 8'(T_B_GREEN - 1);
    localparam logic [7:0] WALK_LAST      = 8'(T_WALK - 1);
    localparam logic [7:0] CNT_MAX        = 8'hFF;

    // Lamp vector order: {a_red, a_amber, a_green, b_red, b_amber, b_green, walk}
    localparam logic [6:0] LAMPS_AG   = 7'b0011000;
    localparam logic [6:0] LAMPS_AA   = 7'b0101000;
    localparam logic [6:0] LAMPS_RED  = 7'b1001000;
    localparam logic [6:0] LAMPS_BRA  = 7'b1001100;
    localparam logic [6:0] LAMPS_BG   = 7'b1000010;
    localparam logic [6:0] LAMPS_BA   = 7'b1000100;
    localparam logic [6:0] LAMPS_ARA  = 7'b1101000;
    localparam logic [6:0] LAMPS_WALK = 7'b1001001;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  next_cnt_s;
    logic        p_pend_r;
    logic        next_p_pend_s;
    logic        b_pend_r;
    logic        next_b_pend_s;
    logic [6:0]  lamps_r;
    logic        state_change_s;
    logic        enter_walk_s;
    logic        enter_bra_s;

    // Lamp pattern for each state. Any unused encoding shows the road-A
    // green pattern, which matches the state it recovers to.
    function automatic logic [6:0] lamp_decode(input state_t st);
        logic [6:0] lamps;
        case (st)
            ST_AG:   lamps = LAMPS_AG;
            ST_AA:   lamps = LAMPS_AA;
            ST_AR1:  lamps = LAMPS_RED;
            ST_BRA:  lamps = LAMPS_BRA;
            ST_BG:   lamps = LAMPS_BG;
            ST_BA:   lamps = LAMPS_BA;
            ST_AR2:  lamps = LAMPS_RED;
            ST_ARA:  lamps = LAMPS_ARA;
            ST_WALK: lamps = LAMPS_WALK;
            default: lamps = LAMPS_AG;
        endcase
        return lamps;
    endfunction

    // Next-state logic. Timed states leave when the counter reaches the
    // last value for that state. Any unused encoding returns to AG.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_AG: begin
                if ((cnt_r >= MIN_GREEN_LAST) && (b_pend_r || p_pend_r)) begin
                    next_state_s = ST_AA;
                end else begin
                    next_state_s = ST_AG;
                end
            end
            ST_AA: begin
                if (cnt_r == AMBER_LAST) begin
                    next_state_s = ST_AR1;
                end else begin
                    next_state_s = ST_AA;
                end
            end
            ST_AR1: begin
                // A waiting pedestrian is served before road B.
                if (cnt_r == ALL_RED_LAST) begin
                    if (p_pend_r) begin
                        next_state_s = ST_WALK;
                    end else begin
                        next_state_s = ST_BRA;
                    end
                end else begin
                    next_state_s = ST_AR1;
                end
            end
            ST_BRA: begin
                if (cnt_r == RED_AMBER_LAST) begin
                    next_state_s = ST_BG;
                end else begin
                    next_state_s = ST_BRA;
                end
            end
            ST_BG: begin
                if (cnt_r == B_GREEN_LAST) begin
                    next_state_s = ST_BA;
                end else begin
                    next_state_s = ST_BG;
                end
            end
            ST_BA: begin
                if (cnt_r == AMBER_LAST) begin
                    next_state_s = ST_AR2;
                end else begin
                    next_state_s = ST_BA;
                end
            end
            ST_WALK: begin
                if (cnt_r == WALK_LAST) begin
                    next_state_s = ST_AR2;
                end else begin
                    next_state_s = ST_WALK;
                end
            end
            ST_AR2: begin
                if (cnt_r == ALL_RED_LAST) begin
                    next_state_s = ST_ARA;
                end else begin
                    next_state_s = ST_AR2;
                end
            end
            ST_ARA: begin
                if (cnt_r == RED_AMBER_LAST) begin
                    next_state_s = ST_AG;
                end else begin
                    next_state_s = ST_ARA;
                end
            end
            default: begin
                next_state_s = ST_AG;
            end
        endcase
    end

    // Counter and pending-request updates. A clear on entry to WALK or BRA
    // overrides a request that arrives in the same cycle.
    always_comb begin
        state_change_s = (next_state_s != state_r);
        enter_walk_s   = state_change_s && (next_state_s == ST_WALK);
        enter_bra_s    = state_change_s && (next_state_s == ST_BRA);

        if (state_change_s) begin
            next_cnt_s = 8'd0;
        end else if (cnt_r == CNT_MAX) begin
            next_cnt_s = cnt_r;
        end else begin
            next_cnt_s = cnt_r + 8'd1;
        end

        if (enter_walk_s) begin
            next_p_pend_s = 1'b0;
        end else begin
            next_p_pend_s = p_pend_r | ped_req;
        end

        // A car seen while road B is already in its red+amber or green
        // phase is being served now, so it does not raise a new request.
        if (enter_bra_s) begin
            next_b_pend_s = 1'b0;
        end else if (car_b && (state_r != ST_BRA) && (state_r != ST_BG)) begin
            next_b_pend_s = 1'b1;
        end else begin
            next_b_pend_s = b_pend_r;
        end
    end

    // State, counter, pending flags and lamp register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_AG;
            cnt_r    <= 8'd0;
            p_pend_r <= 1'b0;
            b_pend_r <= 1'b0;
            lamps_r  <= LAMPS_AG;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= next_cnt_s;
            p_pend_r <= next_p_pend_s;
            b_pend_r <= next_b_pend_s;
            lamps_r  <= lamp_decode(next_state_s);
        end
    end

    assign a_red   = lamps_r[6];
    assign a_amber = lamps_r[5];
    assign a_green = lamps_r[4];
    assign b_red   = lamps_r[3];
    assign b_amber = lamps_r[2];
    assign b_green = lamps_r[1];
    assign walk    = lamps_r[0];

endmodule

// File: tb/tb_junction_controller.sv
// ---------------------------------------------------------------------------
// tb_junction_controller
//
// Self-checking bench for junction_controller. A phase-level reference
// model tracks the current phase, the time spent in it and the two pending
// requests. A compare process checks every cycle outside reset against the
// model and against the lamp-safety rules. Literal expectations at chosen
// cycles of the directed scenarios check both the model and the DUT.
// ---------------------------------------------------------------------------
module tb_junction_controller;

    localparam int T_MIN_GREEN = 8;
    localparam int T_AMBER     = 3;
    localparam int T_RED_AMBER = 2;
    localparam int T_ALL_RED   = 1;
    localparam int T_B_GREEN   = 6;
    localparam int T_WALK      = 5;

    // {a_red, a_amber, a_green, b_red, b_amber, b_green, walk}
    localparam logic [6:0] L_AG   = 7'b0011000;
    localparam logic [6:0] L_AA   = 7'b0101000;
    localparam logic [6:0] L_RED  = 7'b1001000;
    localparam logic [6:0] L_BRA  = 7'b1001100;
    localparam logic [6:0] L_BG   = 7'b1000010;
    localparam logic [6:0] L_BA   = 7'b1000100;
    localparam logic [6:0] L_ARA  = 7'b1101000;
    localparam logic [6:0] L_WALK = 7'b1001001;

    // Model phase numbers
    localparam int P_AG = 0, P_AA = 1, P_AR1 = 2, P_BRA = 3, P_BG = 4,
                   P_BA = 5, P_AR2 = 6, P_ARA = 7, P_WALK = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic car_b = 1'b0;
    logic ped_req = 1'b0;
    logic a_red, a_amber, a_green, b_red, b_amber, b_green, walk;

    int n_pass = 0;
    int n_total = 0;

    int   m_ph = P_AG;
    int   m_t  = 0;
    bit   m_pp = 1'b0;
    bit   m_bp = 1'b0;
    int   m_nx;

    logic [6:0] hist_d [0:127];
    logic [6:0] hist_m [0:127];
    logic [6:0] dut_lamps;

    junction_controller #(
        .T_MIN_GREEN(T_MIN_GREEN), .T_AMBER(T_AMBER), .T_RED_AMBER(T_RED_AMBER),
        .T_ALL_RED(T_ALL_RED), .T_B_GREEN(T_B_GREEN), .T_WALK(T_WALK)
    ) dut (
        .clk(clk), .rst(rst), .car_b(car_b), .ped_req(ped_req),
        .a_red(a_red), .a_amber(a_amber), .a_green(a_green),
        .b_red(b_red), .b_amber(b_amber), .b_green(b_green), .walk(walk)
    );

    always #5 clk = ~clk;

    assign dut_lamps = {a_red, a_amber, a_green, b_red, b_amber, b_green, walk};

    // ---------------- reference model ----------------
    function automatic logic [6:0] lamps_of(input int ph);
        case (ph)
            P_AG:    return L_AG;
            P_AA:    return L_AA;
            P_AR1:   return L_RED;
            P_BRA:   return L_BRA;
            P_BG:    return L_BG;
            P_BA:    return L_BA;
            P_AR2:   return L_RED;
            P_ARA:   return L_ARA;
            P_WALK:  return L_WALK;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int dur_of(input int ph);
        case (ph)
            P_AA, P_BA:   return T_AMBER;
            P_AR1, P_AR2: return T_ALL_RED;
            P_BRA, P_ARA: return T_RED_AMBER;
            P_BG:         return T_B_GREEN;
            P_WALK:       return T_WALK;
            default:      return 0;
        endcase
    endfunction

    // Phase after this cycle, given the cycles already spent in the phase.
    function automatic int next_of(input int ph, input int t, input bit pp, input bit bp);
        int e;
        e = t + 1;
        if (ph == P_AG) return (e >= T_MIN_GREEN && (pp || bp)) ? P_AA : P_AG;
        if (e < dur_of(ph)) return ph;
        case (ph)
            P_AA:    return P_AR1;
            P_AR1:   return pp ? P_WALK : P_BRA;
            P_BRA:   return P_BG;
            P_BG:    return P_BA;
            P_BA:    return P_AR2;
            P_WALK:  return P_AR2;
            P_AR2:   return P_ARA;
            P_ARA:   return P_AG;
            default: return P_AG;
        endcase
    endfunction

    assign m_nx = next_of(m_ph, m_t, m_pp, m_bp);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_AG;
            m_t  <= 0;
            m_pp <= 1'b0;
            m_bp <= 1'b0;
        end else begin
            m_ph <= m_nx;
            m_t  <= (m_nx == m_ph) ? m_t + 1 : 0;
            m_pp <= (m_nx == P_WALK && m_ph != P_WALK) ? 1'b0 : (m_pp | ped_req);
            m_bp <= (m_nx == P_BRA && m_ph != P_BRA) ? 1'b0
                  : (m_bp | (car_b && m_ph != P_BRA && m_ph != P_BG));
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    endtask

    // Every cycle outside reset: lamps against the model plus safety rules.
    always @(negedge clk) begin
        if (!rst) begin
            check("lamps_vs_model", dut_lamps, lamps_of(m_ph));
            check("a_b_conflict", {6'd0, ((a_green | a_amber) & (b_green | b_amber))}, 7'd0);
            check("walk_conflict",
                  {6'd0, (walk & (a_green | a_amber | b_green | b_amber))}, 7'd0);
        end
    end

    task automatic lit(input string name, input int c, input logic [6:0] exp);
        check({name, "_dut"}, hist_d[c], exp);
        check({name, "_model"}, hist_m[c], exp);
    endtask

    // Holds reset over two edges, releases it 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        car_b = 1'b0;
        ped_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs n cycles from cycle 0 with one-cycle pulses at the given cycles.
    // A negative cycle number means no pulse.
    task automatic run(input int n, input int car_at, input int ped_at);
        for (int c = 0; c < n; c++) begin
            car_b   = (c == car_at);
            ped_req = (c == ped_at);
            @(negedge clk);
            hist_d[c] = dut_lamps;
            hist_m[c] = lamps_of(m_ph);
            @(posedge clk); #1;
        end
        car_b = 1'b0;
        ped_req = 1'b0;
    endtask

    initial begin
        // Idle: road A green throughout.
        do_reset();
        check("reset_lamps", dut_lamps, L_AG);
        run(100, -1, -1);
        lit("idle_c0", 0, L_AG);
        lit("idle_c50", 50, L_AG);
        lit("idle_c99", 99, L_AG);

        // Road-B service from a car pulse at cycle 2.
        do_reset();
        run(40, 2, -1);
        lit("b_ag_c7", 7, L_AG);
        lit("b_aa_c8", 8, L_AA);
        lit("b_aa_c10", 10, L_AA);
        lit("b_ar1_c11", 11, L_RED);
        lit("b_bra_c12", 12, L_BRA);
        lit("b_bra_c13", 13, L_BRA);
        lit("b_bg_c14", 14, L_BG);
        lit("b_bg_c19", 19, L_BG);
        lit("b_ba_c20", 20, L_BA);
        lit("b_ba_c22", 22, L_BA);
        lit("b_ar2_c23", 23, L_RED);
        lit("b_ara_c24", 24, L_ARA);
        lit("b_ara_c25", 25, L_ARA);
        lit("b_ag_c26", 26, L_AG);
        lit("b_ag_c39", 39, L_AG);

        // Pedestrian pulse at cycle 20, past minimum green.
        do_reset();
        run(45, -1, 20);
        lit("p_ag_c21", 21, L_AG);
        lit("p_aa_c22", 22, L_AA);
        lit("p_ar1_c25", 25, L_RED);
        lit("p_walk_c26", 26, L_WALK);
        lit("p_walk_c30", 30, L_WALK);
        lit("p_ar2_c31", 31, L_RED);
        lit("p_ara_c32", 32, L_ARA);
        lit("p_ag_c34", 34, L_AG);
        lit("p_ag_c44", 44, L_AG);

        // Both requests at cycle 0: walk first, then fresh minimum green, then B.
        do_reset();
        run(50, 0, 0);
        lit("pb_walk_c12", 12, L_WALK);
        lit("pb_walk_c16", 16, L_WALK);
        lit("pb_ar2_c17", 17, L_RED);
        lit("pb_ag_c20", 20, L_AG);
        lit("pb_ag_c27", 27, L_AG);
        lit("pb_aa_c28", 28, L_AA);
        lit("pb_bra_c32", 32, L_BRA);
        lit("pb_bg_c34", 34, L_BG);
        lit("pb_ag_c46", 46, L_AG);

        // Asynchronous reset in the third cycle of BG (cycle 16).
        do_reset();
        run(16, 0, -1);
        lit("r_bg_c15", 15, L_BG);
        #1;
        check("r_bg_c16_before", dut_lamps, L_BG);
        rst = 1'b1;
        #1;
        check("r_async_lamps", dut_lamps, L_AG);
        @(posedge clk); #1;
        check("r_held_lamps", dut_lamps, L_AG);
        rst = 1'b0;
        run(30, -1, -1);
        lit("r_hold_c29", 29, L_AG);

        // Randomized traffic, with one asynchronous reset midway.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            car_b   = ($urandom_range(0, 9) == 0);
            ped_req = ($urandom_range(0, 29) == 0);
            if (i == 5000) begin
                #2 rst = 1'b1;
                #1;
                check("rand_async_lamps", dut_lamps, L_AG);
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        car_b = 1'b0;
        ped_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
